// File: rtl/diff_pkg.sv
// Shared encodings for the sequential differing-bit scan unit.
package diff_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic MODE_LSB = 1'b0;
    localparam logic MODE_MSB = 1'b1;

endpackage

// File: rtl/diff_prio_enc.sv
// Chunk priority encoder: finds the lowest or highest set bit of one chunk.
module diff_prio_enc
    import diff_pkg::*;
#(
    parameter int CHUNK = 8,
    localparam int OW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             dir,
    output logic [OW-1:0]    offset,
    output logic             hit
);

    // Later loop iterations win, so the loop order picks the direction.
    always_comb begin
        offset = '0;
        hit    = 1'b0;
        if (dir == MODE_LSB) begin
            for (int i = CHUNK - 1; i >= 0; i--) begin
                if (chunk[i]) begin
                    hit    = 1'b1;
                    offset = OW'(i);
                end
            end
        end else begin
            for (int i = 0; i < CHUNK; i++) begin
                if (chunk[i]) begin
                    hit    = 1'b1;
                    offset = OW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/diff_scan_unit.sv
// Multi-cycle lowest/highest differing-bit unit scanning a^b CHUNK bits per cycle.
// Define DIFF_POPCNT_EN to add the hamming output (disables early termination).
module diff_scan_unit
    import diff_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  diff_idx,
    output logic             eq
`ifdef DIFF_POPCNT_EN
    ,
    output logic [IDXW:0]    hamming
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             mode_q, mode_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             eq_q, eq_d;

    logic [PW-1:0]    cidx;
    logic [CHUNK-1:0] chunk;
    logic [OW-1:0]    offset;
    logic             hit;
    logic [IDXW-1:0]  hit_idx;
    logic             last;

`ifdef DIFF_POPCNT_EN
    logic [IDXW:0]    acc_q, acc_d;
    logic [IDXW:0]    pc;
    logic             found_q, found_d;
`endif

    // MSB mode walks chunks from the top down.
    assign cidx    = (mode_q == MODE_MSB) ? PW'(NCH - 1) - ptr_q : ptr_q;
    assign chunk   = x_q[int'(cidx) * CHUNK +: CHUNK];
    assign hit_idx = IDXW'(int'(cidx) * CHUNK + int'(offset));
    assign last    = (ptr_q == PW'(NCH - 1));

    diff_prio_enc #(.CHUNK(CHUNK)) u_enc (
        .chunk  (chunk),
        .dir    (mode_q),
        .offset (offset),
        .hit    (hit)
    );

`ifdef DIFF_POPCNT_EN
    always_comb begin
        pc = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pc = pc + (IDXW + 1)'(chunk[i]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            ptr_q   <= '0;
            mode_q  <= MODE_LSB;
            idx_q   <= '0;
            eq_q    <= 1'b0;
`ifdef DIFF_POPCNT_EN
            acc_q   <= '0;
            found_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
`ifdef DIFF_POPCNT_EN
            acc_q   <= acc_d;
            found_q <= found_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
`ifdef DIFF_POPCNT_EN
        acc_d   = acc_q;
        found_d = found_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = a ^ b;
                    mode_d  = mode;
                    ptr_d   = '0;
                    state_d = S_SCAN;
`ifdef DIFF_POPCNT_EN
                    acc_d   = '0;
                    found_d = 1'b0;
`endif
                end
            end
            S_SCAN: begin
`ifdef DIFF_POPCNT_EN
                acc_d = acc_q + pc;
                if (hit && !found_q) begin
                    idx_d   = hit_idx;
                    found_d = 1'b1;
                end
                if (last) begin
                    eq_d    = !(found_q || hit);
                    if (!(found_q || hit)) idx_d = '0;
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
`else
                if (hit) begin
                    idx_d   = hit_idx;
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (last) begin
                    idx_d   = '0;
                    eq_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
`endif
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        diff_idx  = idx_q;
        eq        = eq_q;
`ifdef DIFF_POPCNT_EN
        hamming   = acc_q;
`endif
    end

endmodule
